// File: rtl/memory_responder.sv
// Memory-side slave of the CPU memory bus: answers level-held readM/writeM
// requests after a fixed latency with a one-cycle inputReady/ackOutput pulse.
module memory_responder #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 inputReady,
  output logic                 ackOutput,
  output logic                 err
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   op_write;
  logic [ADDR_BITS-1:0]   idx;
  logic [WORD_SIZE-1:0]   wdata;
  logic                   drive_en;
  logic [WORD_SIZE-1:0]   mem [DEPTH];

  // Upper address bits alias onto the same words and are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address[WORD_SIZE-1:ADDR_BITS];

  // Tri-state read driver; never fights a requester that is driving a write.
  assign data = (drive_en && !writeM) ? mem[idx] : {WORD_SIZE{1'bz}};

  // Request FSM with registered pulses, bus enable and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op_write   <= 1'b0;
      idx        <= '0;
      wdata      <= '0;
      drive_en   <= 1'b0;
      inputReady <= 1'b0;
      ackOutput  <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          inputReady <= 1'b0;
          ackOutput  <= 1'b0;
          drive_en   <= 1'b0;
          if (readM && writeM) begin
            err <= 1'b1;
          end else if (readM || writeM) begin
            op_write <= writeM;
            idx      <= address[ADDR_BITS-1:0];
            if (writeM) wdata <= data;
            cnt      <= CNT_INIT;
            state    <= (CNT_INIT == '0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!(op_write ? writeM : readM)) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else if (cnt == CNT_W'(1)) begin
            cnt   <= '0;
            state <= S_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (op_write) begin
            ackOutput <= 1'b1;
          end else begin
            inputReady <= 1'b1;
            drive_en   <= 1'b1;
          end
          state <= S_HOLD;
        end
        S_HOLD: begin
          inputReady <= 1'b0;
          ackOutput  <= 1'b0;
          drive_en   <= 1'b0;
          if (!readM && !writeM) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // A write strobe while read data is on the bus is a protocol violation.
      if (drive_en && writeM) err <= 1'b1;
    end
  end

  // Storage array; commits the latched write word as the write completes.
  always_ff @(posedge clk) begin
    if (state == S_RESP && op_write) mem[idx] <= wdata;
  end

endmodule
